// File: rtl/test_8_pkg.sv
// -----------------------------------------------------------------------------
// test_8_pkg
// Shared constants for the decode-stage immediate-extension unit.
//   IMM_W / WORD_W : immediate input width and extended operand width
//   EXT_*          : encodings of the ext_op extension-mode select
// -----------------------------------------------------------------------------
package test_8_pkg;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;
    localparam logic [1:0] EXT_BR   = 2'b11;

endpackage

// File: rtl/test_8_if.sv
// -----------------------------------------------------------------------------
// test_8_if
// Bundles the immediate-extension unit's data signals.
//   master : drives A, ext_op, en; observes B, B_q, valid_q, neg_q
//   slave  : the extension unit itself (inverse directions)
// -----------------------------------------------------------------------------
interface test_8_if;
    import test_8_pkg::*;

    logic [IMM_W-1:0]  A;
    logic [1:0]        ext_op;
    logic              en;
    logic [WORD_W-1:0] B;
    logic [WORD_W-1:0] B_q;
    logic              valid_q;
    logic              neg_q;

    modport master (
        output A, ext_op, en,
        input  B, B_q, valid_q, neg_q
    );

    modport slave (
        input  A, ext_op, en,
        output B, B_q, valid_q, neg_q
    );

endinterface

// File: rtl/imm_ext_comb.sv
// -----------------------------------------------------------------------------
// imm_ext_comb
// Pure combinational immediate extender.
//   A      : 16-bit immediate
//   ext_op : extension mode (sign / zero / load-upper / branch word offset)
//   B      : 32-bit extended operand
// -----------------------------------------------------------------------------
module imm_ext_comb
    import test_8_pkg::*;
(
    input  logic [IMM_W-1:0]  A,
    input  logic [1:0]        ext_op,
    output logic [WORD_W-1:0] B
);

    // Every mode is a pure bit rearrangement, so no adder is involved.
    // The branch offset replicates A[15] into the top 14 bits so the
    // word offset stays signed after the shift by two.
    always_comb begin
        B = {{(WORD_W-IMM_W){A[IMM_W-1]}}, A};
        case (ext_op)
            EXT_SIGN: B = {{(WORD_W-IMM_W){A[IMM_W-1]}}, A};
            EXT_ZERO: B = {{(WORD_W-IMM_W){1'b0}}, A};
            EXT_LUI:  B = {A, {(WORD_W-IMM_W){1'b0}}};
            EXT_BR:   B = {{(WORD_W-IMM_W-2){A[IMM_W-1]}}, A, 2'b00};
            default:  B = {{(WORD_W-IMM_W){A[IMM_W-1]}}, A};
        endcase
    end

endmodule

// File: rtl/test_8.sv
// -----------------------------------------------------------------------------
// test_8
// Immediate-extension unit with an optional registered copy of the result.
//   clk      : clock for the registered outputs only
//   rst      : synchronous active-high reset of the registered outputs
//   bus      : test_8_if.slave
//              A, ext_op -> B (combinational)
//              en        -> captures B into B_q / neg_q and sets valid_q
// -----------------------------------------------------------------------------
module test_8
    import test_8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    test_8_if.slave    bus
);

    logic [WORD_W-1:0] b_comb;
    logic [WORD_W-1:0] b_reg;
    logic              valid_reg;
    logic              neg_reg;

    imm_ext_comb u_comb (
        .A      (bus.A),
        .ext_op (bus.ext_op),
        .B      (b_comb)
    );

    // Reset takes priority over a capture in the same cycle; with en low
    // the registers simply hold. valid stays set until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg     <= '0;
            valid_reg <= 1'b0;
            neg_reg   <= 1'b0;
        end else if (bus.en) begin
            b_reg     <= b_comb;
            neg_reg   <= b_comb[WORD_W-1];
            valid_reg <= 1'b1;
        end
    end

    assign bus.B       = b_comb;
    assign bus.B_q     = b_reg;
    assign bus.valid_q = valid_reg;
    assign bus.neg_q   = neg_reg;

endmodule

// File: tb/tb_test_8.sv
// -----------------------------------------------------------------------------
// tb_test_8
// Self-checking bench for test_8: directed steps followed by a randomized
// run compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_test_8;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    logic [31:0] exp_bq;
    logic        exp_valid;
    logic        exp_neg;

    test_8_if bus ();

    test_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the extension modes as signed/unsigned arithmetic.
    function automatic logic [31:0] ext_model(input logic [15:0] a, input logic [1:0] op);
        int s;
        s = int'($signed(a));
        case (op)
            2'd0:    return 32'(s);
            2'd1:    return 32'(a);
            2'd2:    return 32'(a) * 32'd65536;
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic applyStimulus(input logic r, input logic e,
                                 input logic [15:0] a, input logic [1:0] op);
        rst        = r;
        bus.en     = e;
        bus.A      = a;
        bus.ext_op = op;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, " B_q"},     bus.B_q,            exp_bq);
        checkOutput({tag, " valid_q"}, {31'd0, bus.valid_q}, {31'd0, exp_valid});
        checkOutput({tag, " neg_q"},   {31'd0, bus.neg_q},   {31'd0, exp_neg});
    endtask

    initial begin
        logic [15:0] ra;
        logic [1:0]  rop;
        logic        rr;
        logic        re;
        logic [31:0] eb;

        checks = 0;
        passes = 0;

        // Reset for one edge
        applyStimulus(1'b1, 1'b0, 16'h0000, 2'b00);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00);
        exp_bq = 32'h0; exp_valid = 1'b0; exp_neg = 1'b0;
        checkRegs("reset");

        // Combinational modes
        applyStimulus(1'b0, 1'b0, 16'hfc57, 2'b00); #1;
        checkOutput("sext neg", bus.B, 32'hffff_fc57);
        applyStimulus(1'b0, 1'b0, 16'h0c57, 2'b00); #1;
        checkOutput("sext pos", bus.B, 32'h0000_0c57);
        applyStimulus(1'b0, 1'b0, 16'hfc57, 2'b01); #1;
        checkOutput("zext", bus.B, 32'h0000_fc57);
        applyStimulus(1'b0, 1'b0, 16'hfc57, 2'b10); #1;
        checkOutput("lui", bus.B, 32'hfc57_0000);
        applyStimulus(1'b0, 1'b0, 16'hfc57, 2'b11); #1;
        checkOutput("br neg", bus.B, 32'hffff_f15c);
        applyStimulus(1'b0, 1'b0, 16'h0001, 2'b11); #1;
        checkOutput("br pos", bus.B, 32'h0000_0004);

        // Capture
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 16'hfc57, 2'b00);
        @(negedge clk);
        exp_bq = 32'hffff_fc57; exp_valid = 1'b1; exp_neg = 1'b1;
        checkRegs("capture");

        // Hold while A changes
        applyStimulus(1'b0, 1'b0, 16'h0c57, 2'b00);
        @(negedge clk);
        checkRegs("hold");
        checkOutput("hold B tracks", bus.B, 32'h0000_0c57);

        // Reset beats enable
        applyStimulus(1'b1, 1'b1, 16'h8000, 2'b00);
        @(negedge clk);
        exp_bq = 32'h0; exp_valid = 1'b0; exp_neg = 1'b0;
        checkRegs("rst+en");
        checkOutput("rst B tracks", bus.B, 32'hffff_8000);

        // Randomized run against the model
        for (int i = 0; i < 300; i++) begin
            rr  = ($urandom_range(0, 15) == 0);
            re  = $urandom_range(0, 1) == 1;
            ra  = 16'($urandom);
            rop = 2'($urandom_range(0, 3));
            applyStimulus(rr, re, ra, rop);
            #1;
            eb = ext_model(ra, rop);
            checkOutput("rand B", bus.B, eb);
            if (rr) begin
                exp_bq = 32'h0; exp_valid = 1'b0; exp_neg = 1'b0;
            end else if (re) begin
                exp_bq = eb; exp_valid = 1'b1; exp_neg = eb[31];
            end
            @(negedge clk);
            checkRegs("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
